// File: rtl/text_stream_sequencer.sv
// Plays zero-terminated ASCII messages out of an external synchronous ROM
// as a valid/ready character stream, with optional pacing gap and looping.
module text_stream_sequencer #(
  parameter logic [7:0] BASE0   = 8'd0,
  parameter logic [7:0] BASE1   = 8'd64,
  parameter logic [7:0] BASE2   = 8'd128,
  parameter logic [7:0] BASE3   = 8'd192,
  parameter int         MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] msg_sel,
  input  logic       loop,
  input  logic [7:0] gap,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       busy,
  output logic       done
);

  localparam int IW = $clog2(MAX_LEN + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WAIT    = 3'd1;
  localparam logic [2:0] CHECK   = 3'd2;
  localparam logic [2:0] PRESENT = 3'd3;
  localparam logic [2:0] PACE    = 3'd4;
  localparam logic [2:0] END     = 3'd5;

  logic [2:0]    state;
  logic [1:0]    sel;
  logic [IW-1:0] idx;
  logic [7:0]    cnt;

  function automatic logic [7:0] base_of(input logic [1:0] s);
    case (s)
      2'd0:    base_of = BASE0;
      2'd1:    base_of = BASE1;
      2'd2:    base_of = BASE2;
      default: base_of = BASE3;
    endcase
  endfunction

  // done is decoded from the END state so it tracks the state exactly,
  // including when ena freezes the machine.
  assign busy = (state != IDLE);
  assign done = (state == END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      idx        <= '0;
      cnt        <= '0;
      rom_addr   <= '0;
      char_out   <= '0;
      char_valid <= 1'b0;
    end else if (ena) begin
      if (state != IDLE && stop) begin
        state      <= IDLE;
        char_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              rom_addr <= base_of(msg_sel);
              sel      <= msg_sel;
              idx      <= '0;
              state    <= WAIT;
            end
          end
          WAIT: state <= CHECK;
          CHECK: begin
            if (rom_data == 8'h00) begin
              state <= END;
            end else begin
              char_out   <= rom_data;
              char_valid <= 1'b1;
              state      <= PRESENT;
            end
          end
          PRESENT: begin
            // char_valid is already high here, so acceptance can never
            // coincide with the edge on which it rises.
            if (char_ready) begin
              char_valid <= 1'b0;
              idx        <= idx + IW'(1);
              rom_addr   <= rom_addr + 8'd1;
              cnt        <= gap;
              state      <= PACE;
            end
          end
          PACE: begin
            if (cnt == 8'd0) begin
              state <= (idx == MAX_LEN[IW-1:0]) ? END : WAIT;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          END: begin
            if (loop) begin
              rom_addr <= base_of(sel);
              idx      <= '0;
              state    <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_stream_sequencer.sv
// Directed bench for text_stream_sequencer with a behavioural synchronous ROM.
module tb_text_stream_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       stop;
  logic [1:0] msg_sel;
  logic       loop;
  logic [7:0] gap;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       busy;
  logic       done;

  logic [7:0] rom [256];

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    logic       ena, start, stop;
    logic [1:0] sel;
    logic       ready;
    logic       cv;
    logic [7:0] co;
    logic       busy, done;
    logic [7:0] addr;
  } vec_t;

  vec_t vecs[$];

  text_stream_sequencer #(
    .BASE0(8'd0), .BASE1(8'd64), .BASE2(8'd128), .BASE3(8'd192), .MAX_LEN(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop),
    .msg_sel(msg_sel), .loop(loop), .gap(gap), .rom_addr(rom_addr),
    .rom_data(rom_data), .char_out(char_out), .char_valid(char_valid),
    .char_ready(char_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cv(input string name);
    int n = 0;
    while (char_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(name, {31'd0, char_valid}, 32'd1);
  endtask

  function automatic vec_t mk(input logic e, s, p, input logic [1:0] m, input logic r,
                              input logic v, input logic [7:0] c, input logic b, d,
                              input logic [7:0] a);
    vec_t t;
    t.ena = e; t.start = s; t.stop = p; t.sel = m; t.ready = r;
    t.cv = v; t.co = c; t.busy = b; t.done = d; t.addr = a;
    return t;
  endfunction

  initial begin
    int n, ndone, nacc, busy_low, bad_done;
    bit chk_base, saw_done;

    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0] = 8'h41; rom[1] = 8'h67; rom[2] = 8'h75; rom[3] = 8'h61; rom[4] = 8'h00;
    rom[64] = 8'h48; rom[65] = 8'h69; rom[66] = 8'h00;
    for (int i = 0; i < 64; i++) rom[192 + i] = 8'h30 + 8'(i);

    // "Agua" playback, stall on 'g' for 5 cycles, frozen cycle, ignored start
    vecs.push_back(mk(1,1,0,0,1, 0,8'h00,1,0,8'd0));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h00,1,0,8'd0));
    vecs.push_back(mk(1,0,0,0,1, 1,8'h41,1,0,8'd0));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h41,1,0,8'd1));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h41,1,0,8'd1));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h41,1,0,8'd1));
    vecs.push_back(mk(1,0,0,0,0, 1,8'h67,1,0,8'd1));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1,1,0,3,0, 1,8'h67,1,0,8'd1));
    vecs.push_back(mk(0,1,0,2,1, 1,8'h67,1,0,8'd1));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h67,1,0,8'd2));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h67,1,0,8'd2));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h67,1,0,8'd2));
    vecs.push_back(mk(1,0,0,0,1, 1,8'h75,1,0,8'd2));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h75,1,0,8'd3));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h75,1,0,8'd3));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h75,1,0,8'd3));
    vecs.push_back(mk(1,0,0,0,1, 1,8'h61,1,0,8'd3));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h61,1,0,8'd4));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h61,1,0,8'd4));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h61,1,0,8'd4));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h61,1,1,8'd4));
    vecs.push_back(mk(1,0,0,0,1, 0,8'h61,0,0,8'd4));
    vecs.push_back(mk(1,1,1,1,1, 0,8'h61,0,0,8'd4));

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; stop = 1'b0; msg_sel = 2'd0;
    loop = 1'b0; gap = 8'd0; char_ready = 1'b1;
    step(); step();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset cv", {31'd0, char_valid}, 32'd0);
    chk("reset char", {24'd0, char_out}, 32'h00);
    chk("reset addr", {24'd0, rom_addr}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      ena = vecs[i].ena; start = vecs[i].start; stop = vecs[i].stop;
      msg_sel = vecs[i].sel; char_ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d cv", i), {31'd0, char_valid}, {31'd0, vecs[i].cv});
      chk($sformatf("vec%0d char", i), {24'd0, char_out}, {24'd0, vecs[i].co});
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      chk($sformatf("vec%0d done", i), {31'd0, done}, {31'd0, vecs[i].done});
      chk($sformatf("vec%0d addr", i), {24'd0, rom_addr}, {24'd0, vecs[i].addr});
    end

    // gap=3 on message 1: handshake edge to next character is gap+1 pace
    // cycles plus WAIT and CHECK
    ena = 1'b1; stop = 1'b0; start = 1'b1; msg_sel = 2'd1; gap = 8'd3; char_ready = 1'b0;
    step();
    chk("gap base addr", {24'd0, rom_addr}, 32'd64);
    start = 1'b0;
    wait_cv("gap first cv");
    chk("gap first char", {24'd0, char_out}, 32'h48);
    char_ready = 1'b1;
    step();
    chk("gap hs cv", {31'd0, char_valid}, 32'd0);
    chk("gap hs addr", {24'd0, rom_addr}, 32'd65);
    n = 0;
    do begin step(); n++; end while (char_valid !== 1'b1 && n < 20);
    chk("gap hs to next cv", n, 32'd6);
    chk("gap second char", {24'd0, char_out}, 32'h69);
    step();
    n = 0;
    do begin step(); n++; end while (done !== 1'b1 && n < 20);
    chk("gap hs to done", n, 32'd6);
    step();
    chk("gap idle after", {31'd0, busy}, 32'd0);

    // loop=1 on a two-character message
    gap = 8'd0; loop = 1'b1; msg_sel = 2'd1; start = 1'b1; char_ready = 1'b1;
    step();
    start = 1'b0; msg_sel = 2'd2;
    ndone = 0; busy_low = 0; chk_base = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (chk_base) chk($sformatf("loop base addr edge %0d", k), {24'd0, rom_addr}, 32'd64);
      chk_base = 1'b0;
      if (busy !== 1'b1) busy_low++;
      if (done === 1'b1) begin ndone++; chk_base = 1'b1; end
    end
    chk("loop done pulses", ndone, 32'd3);
    chk("loop busy low cycles", busy_low, 32'd0);
    stop = 1'b1;
    step();
    chk("loop stop busy", {31'd0, busy}, 32'd0);
    chk("loop stop cv", {31'd0, char_valid}, 32'd0);
    chk("loop stop done", {31'd0, done}, 32'd0);
    stop = 1'b0; loop = 1'b0;

    // no terminator from BASE3: MAX_LEN characters, address wraps to 0
    msg_sel = 2'd3; start = 1'b1;
    step();
    chk("maxlen base addr", {24'd0, rom_addr}, 32'd192);
    start = 1'b0;
    nacc = 0; saw_done = 1'b0;
    for (int k = 0; k < 400 && !saw_done; k++) begin
      if (char_valid === 1'b1 && char_ready === 1'b1) begin
        chk($sformatf("maxlen char %0d", nacc), {24'd0, char_out}, {24'd0, 8'h30 + 8'(nacc)});
        nacc++;
      end
      step();
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("maxlen done seen", {31'd0, saw_done}, 32'd1);
    chk("maxlen char count", nacc, 32'd64);
    chk("maxlen addr wrap", {24'd0, rom_addr}, 32'd0);
    step();
    chk("maxlen idle after", {31'd0, busy}, 32'd0);

    // asynchronous reset while a character is presented
    msg_sel = 2'd0; start = 1'b1; char_ready = 1'b0;
    step();
    start = 1'b0;
    wait_cv("rst present cv");
    #2 rst_n = 1'b0;
    #1;
    chk("rst async cv", {31'd0, char_valid}, 32'd0);
    chk("rst async busy", {31'd0, busy}, 32'd0);
    chk("rst async done", {31'd0, done}, 32'd0);
    chk("rst async addr", {24'd0, rom_addr}, 32'd0);
    chk("rst async char", {24'd0, char_out}, 32'h00);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("rst stays idle", {31'd0, busy}, 32'd0);

    // stop during PACE
    gap = 8'd5; char_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_cv("stop present cv");
    step();
    step();
    chk("stop in pace busy", {31'd0, busy}, 32'd1);
    stop = 1'b1;
    step();
    chk("stop busy", {31'd0, busy}, 32'd0);
    chk("stop cv", {31'd0, char_valid}, 32'd0);
    chk("stop done", {31'd0, done}, 32'd0);
    stop = 1'b0;
    bad_done = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) bad_done++;
    end
    chk("stop no done later", bad_done, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/text_stream_sequencer.md
TEXT_STREAM_SEQUENCER -- requirements
Module: text_stream_sequencer

Interface
REQ-001 Parameter BASE0, default 8'd0: ROM start address of message 0.
REQ-002 Parameter BASE1, default 8'd64: ROM start address of message 1.
REQ-003 Parameter BASE2, default 8'd128: ROM start address of message 2.
REQ-004 Parameter BASE3, default 8'd192: ROM start address of message 3.
REQ-005 Parameter MAX_LEN, default 64: maximum characters per message before forced end.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 ena  input  1  high = advance; low = freeze all state and outputs.
REQ-009 start  input  1  level, sampled in IDLE only: begin playback of msg_sel.
REQ-010 stop  input  1  level: abort playback, return to IDLE.
REQ-011 msg_sel  input  2  message index, latched on accepted start.
REQ-012 loop  input  1  sampled at message end: 1 = restart same message.
REQ-013 gap  input  8  idle cycles inserted after each accepted character.
REQ-014 rom_addr  output  8  registered address to external synchronous ROM (1-cycle read latency).
REQ-015 rom_data  input  8  ROM read data, valid one cycle after rom_addr changes.
REQ-016 char_out  output  8  current ASCII character.
REQ-017 char_valid  output  1  char_out holds a character for the consumer.
REQ-018 char_ready  input  1  consumer accepts char_out when char_valid & char_ready.
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 done  output  1  one-cycle pulse at end of each message pass.

Function
REQ-021 FSM states SHALL be IDLE, WAIT, CHECK, PRESENT, PACE, END.
REQ-022 IDLE: start=1 and stop=0 -> rom_addr<=BASE[msg_sel], idx<=0, latch msg_sel, go WAIT; otherwise stay.
REQ-023 WAIT: unconditionally go CHECK (ROM latency cycle).
REQ-024 CHECK: rom_data==8'h00 -> END; else char_out<=rom_data, char_valid<=1, go PRESENT.
REQ-025 Latency: start sampled at edge k -> char_valid high after edge k+2.
REQ-026 PRESENT: char_valid and char_out SHALL hold stable until a cycle with char_ready=1; on that edge char_valid<=0, idx<=idx+1, rom_addr<=rom_addr+1 (8-bit wrap 255->0), go PACE.
REQ-027 PACE: counter loaded with gap on entry; gap==0 -> leave after one cycle; else wait gap additional cycles; then go END if idx==MAX_LEN, else WAIT.
REQ-028 END: done=1 for exactly this cycle; loop=1 -> rom_addr<=BASE[latched sel], idx<=0, go WAIT; loop=0 -> IDLE.
REQ-029 stop=1 in any non-IDLE state SHALL, on the next edge, force IDLE, char_valid<=0, no done pulse; stop and start both high in IDLE -> remain IDLE.
REQ-030 start while busy SHALL be ignored; msg_sel changes while busy SHALL have no effect.
REQ-031 ena=0 SHALL hold state, counters, and all outputs; stop and start are not sampled while ena=0.
REQ-032 Character acceptance with char_ready high on the same edge char_valid rises SHALL NOT occur; acceptance requires char_valid already high.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, rom_addr=0, char_out=8'h00, char_valid=0, busy=0, done=0, idx=0, pace counter=0.
REQ-034 Reset mid-message SHALL discard playback; after release, FSM waits in IDLE for a new start.

Verification
REQ-035 ROM "Agua\0" at 0, msg_sel=0, gap=0, char_ready=1 -> char_out 41,67,75,61, then one done pulse, busy low.
REQ-036 Same, char_ready held 0 for 5 cycles on 'g' -> char_out=8'h67 and char_valid stable all 5 cycles, no address advance.
REQ-037 gap=3, msg_sel=1 -> exactly 4 cycles from each handshake edge to next WAIT; rom_addr starts at 64.
REQ-038 loop=1 on 2-character message -> done pulses every pass, rom_addr returns to base, busy stays high until stop.
REQ-039 No terminator, MAX_LEN=64, BASE3=192 -> 64 characters emitted, rom_addr wraps 255->0, then done.
REQ-040 rst_n low during PRESENT, and separately stop=1 during PACE -> IDLE next edge, char_valid=0, no done.
